// File: rtl/systolic_feeder_if.sv
// RAM read port between systolic_feeder (master) and the weight/activation RAM (slave).
// Read data is valid the cycle after mem_ce.
interface systolic_feeder_if;
  logic        mem_ce;
  logic [14:0] mem_addr;
  logic [31:0] mem_dout;

  modport master (output mem_ce, output mem_addr, input mem_dout);
  modport slave  (input mem_ce, input mem_addr, output mem_dout);
endinterface

// File: rtl/systolic_feeder.sv
// Loads a ROWSxCOLS weight block from RAM, then streams activation words into the array lanes.
// Define SYSTOLIC_FEEDER_SKEW_EN to delay lane i by i cycles (diagonal skew); otherwise lanes move together.
module systolic_feeder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [14:0]                      w_base,
  input  logic [14:0]                      a_base,
  input  logic [15:0]                      a_len,
  systolic_feeder_if.master                mem,
  output logic                             weights_load,
  output logic [ROWS*COLS*DATA_WIDTH-1:0]  weight_data,
  output logic [ROWS*DATA_WIDTH-1:0]       input_data,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  localparam int unsigned IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
`ifdef SYSTOLIC_FEEDER_SKEW_EN
  localparam int unsigned DRAIN_LEN = ROWS + COLS - 1;
`else
  localparam int unsigned DRAIN_LEN = COLS;
`endif

  typedef enum logic [2:0] {IDLE, LOAD_W, LATCH, STREAM, DRAIN, FIN} state_t;

  state_t                                state;
  logic                                  ce_q;
  logic [14:0]                           addr_q;
  logic [14:0]                           a_base_q;
  logic [15:0]                           len_q;
  logic [15:0]                           cnt;
  logic                                  w_pend;
  logic                                  s_pend;
  logic [IDX_W-1:0]                      w_idx;
  logic [ROWS-1:0][COLS*DATA_WIDTH-1:0]  weight_q;

  assign mem.mem_ce   = ce_q;
  assign mem.mem_addr = addr_q;
  assign weight_data  = weight_q;

  // w_pend/s_pend mark the cycle a read issued last cycle has its data on mem_dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      weights_load <= 1'b0;
      ce_q         <= 1'b0;
      addr_q       <= '0;
      a_base_q     <= '0;
      len_q        <= '0;
      cnt          <= '0;
      w_pend       <= 1'b0;
      s_pend       <= 1'b0;
      w_idx        <= '0;
      weight_q     <= '0;
    end else begin
      done         <= 1'b0;
      err          <= 1'b0;
      weights_load <= 1'b0;
      w_pend       <= ce_q && (state == LOAD_W);
      s_pend       <= ce_q && (state == STREAM);
      w_idx        <= cnt[IDX_W-1:0];
      if (w_pend) weight_q[w_idx] <= mem.mem_dout;

      case (state)
        IDLE: begin
          if (start) begin
            if (a_len == '0) begin
              err <= 1'b1;
            end else begin
              state    <= LOAD_W;
              busy     <= 1'b1;
              ce_q     <= 1'b1;
              addr_q   <= w_base;
              a_base_q <= a_base;
              len_q    <= a_len;
              cnt      <= '0;
            end
          end
        end
        LOAD_W: begin
          if (ce_q) begin
            if (cnt == 16'(ROWS - 1)) begin
              ce_q <= 1'b0;
            end else begin
              cnt    <= cnt + 16'd1;
              addr_q <= addr_q + 15'd1;
            end
          end
          if (w_pend && (w_idx == IDX_W'(ROWS - 1))) begin
            weights_load <= 1'b1;
            state        <= LATCH;
          end
        end
        LATCH: begin
          state  <= STREAM;
          ce_q   <= 1'b1;
          addr_q <= a_base_q;
          cnt    <= '0;
        end
        STREAM: begin
          if (cnt == len_q - 16'd1) begin
            ce_q  <= 1'b0;
            cnt   <= '0;
            state <= DRAIN;
          end else begin
            cnt    <= cnt + 16'd1;
            addr_q <= addr_q + 15'd1;
          end
        end
        DRAIN: begin
          if (cnt == 16'(DRAIN_LEN - 1)) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ce_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SYSTOLIC_FEEDER_SKEW_EN
  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] src;
    logic [DATA_WIDTH-1:0] lane_q;
    assign src = s_pend ? mem.mem_dout[DATA_WIDTH*i +: DATA_WIDTH] : '0;
    if (i == 0) begin : g_direct
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lane_q <= '0;
        else        lane_q <= src;
      end
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] dly [i];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned d = 0; d < i; d++) dly[d] <= '0;
          lane_q <= '0;
        end else begin
          dly[0] <= src;
          for (int unsigned d = 1; d < i; d++) dly[d] <= dly[d-1];
          lane_q <= dly[i-1];
        end
      end
    end
    assign input_data[DATA_WIDTH*i +: DATA_WIDTH] = lane_q;
  end
`else
  logic [ROWS*DATA_WIDTH-1:0] in_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_q <= '0;
    else        in_q <= s_pend ? mem.mem_dout : '0;
  end
  assign input_data = in_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: weight load, streaming (skewed or not), zero length,
// address wrap with ignored restart, and reset mid-job.
module tb_systolic_feeder;
  localparam int unsigned DW   = 8;
  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;
`ifdef SYSTOLIC_FEEDER_SKEW_EN
  localparam int DONE_C = 15;
`else
  localparam int DONE_C = 12;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [14:0]  w_base = '0;
  logic [14:0]  a_base = '0;
  logic [15:0]  a_len = '0;
  logic         weights_load, busy, done, err;
  logic [127:0] weight_data;
  logic [31:0]  input_data;

  systolic_feeder_if mif ();

  systolic_feeder #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .w_base       (w_base),
    .a_base       (a_base),
    .a_len        (a_len),
    .mem          (mif),
    .weights_load (weights_load),
    .weight_data  (weight_data),
    .input_data   (input_data),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:32767];
  logic [14:0] rd_log [$];

  always @(posedge clk) begin
    if (mif.mem_ce) begin
      mif.mem_dout <= ram[mif.mem_addr];
      rd_log.push_back(mif.mem_addr);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0]  in_tr   [0:31];
  logic         busy_tr [0:31];
  logic [127:0] w_snap;
  int wl_cnt, wl_first, done_cnt, done_first, err_cnt, err_first;

  task automatic run_job(input logic [14:0] wb, input logic [14:0] ab, input logic [15:0] len,
                         input int restart_at, input int ncyc);
    rd_log.delete();
    wl_cnt = 0; wl_first = -1; done_cnt = 0; done_first = -1; err_cnt = 0; err_first = -1;
    w_snap = '0;
    w_base = wb; a_base = ab; a_len = len; start = 1'b1;
    tick();
    start = 1'b0;
    w_base = '1; a_base = '1; a_len = 16'd7;
    for (int c = 0; c < ncyc; c++) begin
      in_tr[c]   = input_data;
      busy_tr[c] = busy;
      if (weights_load) begin
        wl_cnt++;
        if (wl_first < 0) begin wl_first = c; w_snap = weight_data; end
      end
      if (done) begin done_cnt++; if (done_first < 0) done_first = c; end
      if (err)  begin err_cnt++;  if (err_first < 0)  err_first = c;  end
      if (c == restart_at) begin start = 1'b1; a_len = '0; end
      else start = 1'b0;
      tick();
    end
    start = 1'b0;
  endtask

  function automatic logic [31:0] exp_a(input int c);
`ifdef SYSTOLIC_FEEDER_SKEW_EN
    case (c)
      8:  return 32'h0000_00AA;
      9:  return 32'h0000_BB11;
      10: return 32'h00CC_2200;
      11: return 32'hDD33_0000;
      12: return 32'h4400_0000;
      default: return 32'h0;
    endcase
`else
    case (c)
      8:  return 32'hDDCC_BBAA;
      9:  return 32'h4433_2211;
      default: return 32'h0;
    endcase
`endif
  endfunction

  task automatic check_job_a(input string pfx);
    logic [14:0] exp_rd [6];
    exp_rd = '{15'h10, 15'h11, 15'h12, 15'h13, 15'h20, 15'h21};
    check_val({pfx, "_rd_count"}, 128'(rd_log.size()), 128'd6);
    for (int k = 0; k < 6; k++)
      if (k < rd_log.size()) check_val($sformatf("%s_rd%0d", pfx, k), 128'(rd_log[k]), 128'(exp_rd[k]));
    check_val({pfx, "_wl_cnt"},   128'(wl_cnt),   128'd1);
    check_val({pfx, "_wl_cycle"}, 128'(wl_first), 128'd5);
    check_val({pfx, "_w_row0"}, 128'(w_snap[31:0]),   128'h0403_0201);
    check_val({pfx, "_w_row1"}, 128'(w_snap[63:32]),  128'h0807_0605);
    check_val({pfx, "_w_row2"}, 128'(w_snap[95:64]),  128'h0C0B_0A09);
    check_val({pfx, "_w_row3"}, 128'(w_snap[127:96]), 128'h100F_0E0D);
    check_val({pfx, "_done_cnt"},   128'(done_cnt),   128'd1);
    check_val({pfx, "_done_cycle"}, 128'(done_first), 128'(DONE_C));
    check_val({pfx, "_err_cnt"},    128'(err_cnt),    128'd0);
    check_val({pfx, "_busy_c0"},    128'(busy_tr[0]),        128'd1);
    check_val({pfx, "_busy_fin"},   128'(busy_tr[DONE_C]),   128'd1);
    check_val({pfx, "_busy_after"}, 128'(busy_tr[DONE_C+1]), 128'd0);
    for (int c = 0; c < 20; c++)
      check_val($sformatf("%s_in_c%0d", pfx, c), 128'(in_tr[c]), 128'(exp_a(c)));
  endtask

  task automatic check_all_zero(input string pfx);
    check_val({pfx, "_busy"},  128'(busy),         128'd0);
    check_val({pfx, "_flags"}, 128'({weights_load, done, err}), 128'd0);
    check_val({pfx, "_ce"},    128'(mif.mem_ce),   128'd0);
    check_val({pfx, "_addr"},  128'(mif.mem_addr), 128'd0);
    check_val({pfx, "_wdata"}, weight_data,        128'd0);
    check_val({pfx, "_idata"}, 128'(input_data),   128'd0);
  endtask

  initial begin
    for (int a = 0; a < 32768; a++) ram[a] = '0;
    ram[15'h10]   = 32'h0403_0201;
    ram[15'h11]   = 32'h0807_0605;
    ram[15'h12]   = 32'h0C0B_0A09;
    ram[15'h13]   = 32'h100F_0E0D;
    ram[15'h20]   = 32'hDDCC_BBAA;
    ram[15'h21]   = 32'h4433_2211;
    ram[15'h7FFF] = 32'h8765_4321;
    ram[15'h0]    = 32'h0FED_CBA9;

    // Reset state
    tick(); tick();
    check_all_zero("rst");
    rst_n = 1'b1;
    tick();

    // Weight load plus activation stream, inputs scrambled after start
    run_job(15'h10, 15'h20, 16'd2, -1, 20);
    check_job_a("jobA");

    // Zero length request
    run_job(15'h10, 15'h20, 16'd0, -1, 6);
    check_val("zero_err_cnt",   128'(err_cnt),    128'd1);
    check_val("zero_err_cycle", 128'(err_first),  128'd0);
    check_val("zero_reads",     128'(rd_log.size()), 128'd0);
    check_val("zero_busy",      128'(busy_tr[0] | busy_tr[1]), 128'd0);
    check_val("zero_done",      128'(done_cnt),   128'd0);

    // Address wrap with a zero-length start arriving during STREAM
    run_job(15'h10, 15'h7FFF, 16'd2, 6, 20);
    check_val("wrap_rd_count", 128'(rd_log.size()), 128'd6);
    if (rd_log.size() >= 6) begin
      check_val("wrap_rd4", 128'(rd_log[4]), 128'h7FFF);
      check_val("wrap_rd5", 128'(rd_log[5]), 128'h0000);
    end
    check_val("wrap_done_cnt", 128'(done_cnt), 128'd1);
    check_val("wrap_err_cnt",  128'(err_cnt),  128'd0);
    check_val("wrap_lane0_w0", 128'(in_tr[8][7:0]), 128'h21);
    check_val("wrap_lane0_w1", 128'(in_tr[9][7:0]), 128'hA9);

    // Reset asserted mid-STREAM, between clock edges
    run_job(15'h10, 15'h20, 16'd2, -1, 7);
    check_val("mid_busy_before", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done) done_cnt++;
    end
    check_val("mid_no_done", 128'(done_cnt), 128'd0);
    rst_n = 1'b1;
    tick();
    run_job(15'h10, 15'h20, 16'd2, -1, 20);
    check_job_a("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element width; DATA_WIDTH*ROWS and DATA_WIDTH*COLS SHALL each equal 32.
REQ-002 SHALL have parameter ROWS, default 4, number of array input lanes.
REQ-003 SHALL have parameter COLS, default 4, number of array output columns.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, one-cycle job request.
REQ-007 SHALL have port w_base, input, 15, word address of the weight block.
REQ-008 SHALL have port a_base, input, 15, word address of the activation block.
REQ-009 SHALL have port a_len, input, 16, number of activation words.
REQ-010 SHALL have port mem_ce, output, 1, RAM read strobe.
REQ-011 SHALL have port mem_addr, output, 15, RAM word address.
REQ-012 SHALL have port mem_dout, input, 32, RAM read data, valid one cycle after mem_ce.
REQ-013 SHALL have port weights_load, output, 1, array weight-latch pulse.
REQ-014 SHALL have port weight_data, output, ROWS*COLS*DATA_WIDTH, weight matrix with row k in bits [32k+31:32k].
REQ-015 SHALL have port input_data, output, ROWS*DATA_WIDTH, activation lane vector with lane i in bits [8i+7:8i].
REQ-016 SHALL have ports busy (1, high while not IDLE), done (1, one-cycle completion pulse) and err (1, one-cycle bad-job pulse), all outputs.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD_W, LATCH, STREAM, DRAIN and FIN.
REQ-018 In IDLE, start with a_len!=0 SHALL go to LOAD_W; start with a_len==0 SHALL pulse err on the next cycle and stay IDLE with no RAM reads.
REQ-019 SHALL register w_base, a_base and a_len on accepting start; later changes to these inputs SHALL not affect the running job.
REQ-020 start while busy SHALL be ignored, with no error.
REQ-021 LOAD_W SHALL issue ROWS reads on consecutive cycles at w_base+k; each returned word SHALL be written into weight row k one cycle later.
REQ-022 LATCH SHALL assert weights_load for exactly one cycle, the cycle after the last weight word is captured.
REQ-023 STREAM SHALL issue a_len reads on consecutive cycles at a_base+j, one word per cycle with no bubbles.
REQ-024 Returned word j SHALL drive lane i with byte i; lane i SHALL be delayed by i cycles before reaching input_data (diagonal skew).
REQ-025 input_data SHALL be zero on all lanes not carrying a valid skewed element.
REQ-026 DRAIN SHALL last ROWS+COLS-1 cycles after the last STREAM read data returns, with zero inputs.
REQ-027 FIN SHALL pulse done for one cycle and return to IDLE on the next cycle.
REQ-028 RAM addresses SHALL wrap modulo 2^15 (0x7FFF+1 -> 0x0000).
REQ-029 mem_ce SHALL be high only in cycles that issue a read; the block SHALL never write RAM.

Reset
REQ-030 On rst_n low the block SHALL reset immediately, regardless of clk: state IDLE, every output 0, weight and skew registers 0.
REQ-031 A reset mid-job SHALL abort it without done or err; the first start after reset release SHALL behave as a fresh job.

Configuration
REQ-032 With macro SYSTOLIC_FEEDER_SKEW_EN defined, the REQ-024 skew SHALL be applied and DRAIN SHALL last ROWS+COLS-1 cycles.
REQ-033 Without SYSTOLIC_FEEDER_SKEW_EN, all lanes of word j SHALL appear on input_data together, one cycle after the data returns, DRAIN SHALL last COLS cycles, and no skew registers SHALL be built.

Verification
REQ-034 Weight load: RAM[0x10..0x13]=0x04030201 etc.; start with w_base=0x10 -> four reads at 0x10..0x13, weight_data row0=0x04030201, weights_load high exactly one cycle.
REQ-035 Skewed stream (SKEW_EN): a_base=0x20, a_len=2, RAM[0x20]=0xDDCCBBAA -> lane0=0xAA, lane1=0xBB one cycle later, lane3=0xDD three cycles after lane0.
REQ-036 Unskewed stream (no SKEW_EN): same stimulus -> input_data=0xDDCCBBAA in a single cycle; done arrives COLS cycles after the last data returns.
REQ-037 Zero length: start with a_len=0 -> err pulse the next cycle, mem_ce never asserted, busy stays 0.
REQ-038 Wrap and overlap: a_base=0x7FFF, a_len=2 -> reads at 0x7FFF then 0x0000; a second start during STREAM -> ignored, exactly one done pulse.
REQ-039 Reset mid-job: rst_n low during STREAM -> all outputs 0 at once and no done; a new job after reset completes normally.
